// File: rtl/seg7_scan_decoder.sv
// Recovers the 4-digit hex value from a multiplexed, active-low 7-segment scan.
// Each digit slot is debounced, then decoded into a shadow frame published once all slots are seen.
module seg7_scan_decoder #(
   parameter int unsigned STABLE_CYC  = 8,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  led_o,
   input  logic [3:0]  led_sel,
   input  logic        clr,
   output logic [15:0] value,
   output logic [3:0]  dp,
   output logic        frame_valid,
   output logic [3:0]  seen,
   output logic        err,
   output logic        stall
);

   typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

   localparam logic [7:0] StableMax = 8'(STABLE_CYC);

   state_e      state_q, state_d;
   logic [11:0] s_q, p_q;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] to_q, to_d;
   logic [15:0] shadow_q, shadow_d;
   logic [3:0]  sdp_q, sdp_d;
   logic [15:0] value_q, value_d;
   logic [3:0]  dp_q, dp_d;
   logic        fv_q, fv_d;
   logic [3:0]  seen_q, seen_d;
   logic        err_q, err_d;
   logic        stall_q, stall_d;

   logic [3:0]  sel;
   logic [7:0]  seg;
   logic        sel_ok;
   logic [1:0]  slot;
   logic        same;
   logic [3:0]  nib;
   logic        seg_ok;
   logic        accept;
   logic        acc_ok;
   logic        complete;

   assign sel  = s_q[11:8];
   assign seg  = s_q[7:0];
   assign same = (s_q == p_q);

   always_comb begin
      sel_ok = 1'b1;
      slot   = 2'd0;
      case (sel)
         4'b1110: slot = 2'd0;
         4'b1101: slot = 2'd1;
         4'b1011: slot = 2'd2;
         4'b0111: slot = 2'd3;
         default: sel_ok = 1'b0;
      endcase
   end

   always_comb begin
      nib    = 4'h0;
      seg_ok = 1'b1;
      case (seg[6:0])
         7'h40:   nib = 4'h0;
         7'h79:   nib = 4'h1;
         7'h24:   nib = 4'h2;
         7'h30:   nib = 4'h3;
         7'h19:   nib = 4'h4;
         7'h12:   nib = 4'h5;
         7'h02:   nib = 4'h6;
         7'h78:   nib = 4'h7;
         7'h00:   nib = 4'h8;
         7'h10:   nib = 4'h9;
         7'h08:   nib = 4'hA;
         7'h03:   nib = 4'hB;
         7'h46:   nib = 4'hC;
         7'h21:   nib = 4'hD;
         7'h06:   nib = 4'hE;
         7'h0E:   nib = 4'hF;
         default: seg_ok = 1'b0;
      endcase
   end

   // Starting a stable run counts the current sample as the first; with
   // STABLE_CYC == 1 that sample is accepted immediately.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sel_ok) begin
               cnt_d = 8'd1;
               if (STABLE_CYC == 1) begin
                  accept  = 1'b1;
                  state_d = StHold;
               end else begin
                  state_d = StSettle;
               end
            end
         end
         StSettle: begin
            if (!sel_ok || !same) begin
               state_d = StIdle;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == StableMax) begin
                  accept  = 1'b1;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (!same) begin
               if (sel_ok) begin
                  cnt_d = 8'd1;
                  if (STABLE_CYC == 1) begin
                     accept = 1'b1;
                  end else begin
                     state_d = StSettle;
                  end
               end else begin
                  state_d = StIdle;
                  cnt_d   = 8'd0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign acc_ok   = accept && seg_ok;
   assign complete = (seen_q == 4'hF);

   always_comb begin
      shadow_d = shadow_q;
      sdp_d    = sdp_q;
      if (acc_ok) begin
         shadow_d[{slot, 2'b00} +: 4] = nib;
         sdp_d[slot]                  = ~seg[7];
      end

      value_d = complete ? shadow_q : value_q;
      dp_d    = complete ? sdp_q : dp_q;
      fv_d    = complete;

      // A same-cycle accept on completion starts the next frame.
      if (clr) begin
         seen_d = 4'h0;
      end else if (complete) begin
         seen_d = acc_ok ? ~sel : 4'h0;
      end else begin
         seen_d = seen_q | (acc_ok ? ~sel : 4'h0);
      end

      err_d = !clr && (err_q || (accept && !seg_ok));

      if (clr || accept) begin
         to_d = 16'd0;
      end else if (to_q != 16'hFFFF) begin
         to_d = to_q + 16'd1;
      end else begin
         to_d = to_q;
      end

      stall_d = !clr && (stall_q || (32'(to_q) >= TIMEOUT_CYC));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         s_q      <= '1;
         p_q      <= '1;
         cnt_q    <= 8'd0;
         to_q     <= 16'd0;
         shadow_q <= 16'd0;
         sdp_q    <= 4'd0;
         value_q  <= 16'd0;
         dp_q     <= 4'd0;
         fv_q     <= 1'b0;
         seen_q   <= 4'd0;
         err_q    <= 1'b0;
         stall_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= {led_sel, led_o};
         p_q      <= s_q;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
         shadow_q <= shadow_d;
         sdp_q    <= sdp_d;
         value_q  <= value_d;
         dp_q     <= dp_d;
         fv_q     <= fv_d;
         seen_q   <= seen_d;
         err_q    <= err_d;
         stall_q  <= stall_d;
      end
   end

   assign value       = value_q;
   assign dp          = dp_q;
   assign frame_valid = fv_q;
   assign seen        = seen_q;
   assign err         = err_q;
   assign stall       = stall_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: expected frames are queued as scans are driven
// and popped when frame_valid pulses.
module tb_seg7_scan_decoder;

   localparam int unsigned STABLE  = 4;
   localparam int unsigned TIMEOUT = 64;

   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  d;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [7:0]  led_o;
   logic [3:0]  led_sel;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        frame_valid;
   logic [3:0]  seen;
   logic        err;
   logic        stall;

   frame_t exp_q[$];
   int     n_vec    = 0;
   int     n_err    = 0;
   int     n_frames = 0;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_decoder #(
      .STABLE_CYC  (STABLE),
      .TIMEOUT_CYC (TIMEOUT)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .led_o       (led_o),
      .led_sel     (led_sel),
      .clr         (clr),
      .value       (value),
      .dp          (dp),
      .frame_valid (frame_valid),
      .seen        (seen),
      .err         (err),
      .stall       (stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // All stimulus tasks are entered at a falling edge and return at one.
   task automatic raw(input logic [3:0] sel, input logic [7:0] bus, input int cyc);
      led_sel = sel;
      led_o   = bus;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic show(input int digit, input logic [3:0] nib, input logic dpon, input int cyc);
      logic [3:0] oh;
      oh = 4'b0001 << digit;
      raw(~oh, {~dpon, seg_tab[nib]}, cyc);
   endtask

   task automatic idle(input int cyc);
      raw(4'hF, 8'hFF, cyc);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic scan_frame(input logic [15:0] v, input logic [3:0] d);
      exp_q.push_back('{v: v, d: d});
      for (int i = 0; i < 4; i++) show(i, v[i*4 +: 4], d[i], 10);
      idle(10);
   endtask

   always @(negedge clk) begin : mon
      frame_t f;
      if (frame_valid) begin
         n_frames++;
         if (exp_q.size() == 0) begin
            chk("frame_unexpected", 32'(value), 32'hFFFF_FFFF);
         end else begin
            f = exp_q.pop_front();
            chk("frame_value", 32'(value), 32'(f.v));
            chk("frame_dp", 32'(dp), 32'(f.d));
         end
      end
   end

   initial begin
      rst     = 1'b1;
      clr     = 1'b0;
      led_sel = 4'hF;
      led_o   = 8'hFF;
      repeat (3) @(negedge clk);
      chk("rst_value", 32'(value), 32'h0);
      chk("rst_dp", 32'(dp), 32'h0);
      chk("rst_fv", 32'(frame_valid), 32'h0);
      chk("rst_seen", 32'(seen), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      rst = 1'b0;
      idle(2);

      scan_frame(16'h1234, 4'b0000);
      chk("frames_1", 32'(n_frames), 32'd1);
      chk("seen_after_frame", 32'(seen), 32'h0);
      chk("err_clean", 32'(err), 32'h0);

      scan_frame(16'h5A0F, 4'b0101);
      chk("frames_2", 32'(n_frames), 32'd2);

      // Short glitch at the end of digit1's slot must not replace its nibble.
      exp_q.push_back('{v: 16'h8765, d: 4'b0000});
      show(0, 4'h5, 1'b0, 10);
      show(1, 4'h6, 1'b0, 10);
      raw(4'b1101, 8'h80, 2);
      chk("glitch_seen", 32'(seen), 32'h3);
      chk("glitch_value", 32'(value), 32'h5A0F);
      show(2, 4'h7, 1'b0, 10);
      show(3, 4'h8, 1'b0, 10);
      idle(10);
      chk("frames_3", 32'(n_frames), 32'd3);

      show(0, 4'h3, 1'b0, 10);
      raw(4'b1011, 8'hFF, 10);
      chk("invalid_err", 32'(err), 32'h1);
      chk("invalid_seen", 32'(seen), 32'h1);
      pulse_clr();
      chk("clr_err", 32'(err), 32'h0);
      chk("clr_seen", 32'(seen), 32'h0);

      show(0, 4'h4, 1'b0, 10);
      chk("pre_multi_seen", 32'(seen), 32'h1);
      raw(4'b0011, 8'hC0, 20);
      chk("multi_seen", 32'(seen), 32'h1);
      chk("multi_err", 32'(err), 32'h0);
      idle(2);
      pulse_clr();

      idle(1);
      pulse_clr();
      repeat (63) @(negedge clk);
      chk("stall_early", 32'(stall), 32'h0);
      repeat (3) @(negedge clk);
      chk("stall_set", 32'(stall), 32'h1);
      repeat (20) @(negedge clk);
      chk("stall_hold", 32'(stall), 32'h1);
      pulse_clr();
      chk("stall_clr", 32'(stall), 32'h0);

      show(0, 4'h9, 1'b0, 10);
      show(1, 4'h9, 1'b0, 10);
      show(2, 4'h9, 1'b0, 10);
      chk("partial_seen", 32'(seen), 32'h7);
      #2 rst = 1'b1;
      #1;
      chk("midrst_value", 32'(value), 32'h0);
      chk("midrst_dp", 32'(dp), 32'h0);
      chk("midrst_seen", 32'(seen), 32'h0);
      chk("midrst_fv", 32'(frame_valid), 32'h0);
      chk("midrst_err", 32'(err), 32'h0);
      chk("midrst_stall", 32'(stall), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      scan_frame(16'hABCD, 4'b0000);
      chk("frames_4", 32'(n_frames), 32'd4);

      idle(10);
      chk("sb_left", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reads the multiplexed 7-segment scan (LED_O / LED_SEL) that `top` drives, and rebuilds the 4-digit hex value on display.
- Used in bench/debug harnesses to check the displayed result against an expected 16-bit value without eyeballing waveforms.
- Same clock domain as the scan driver. Inputs are registered once, then debounced per digit slot.

Parameters:
- STABLE_CYC, 8, consecutive identical clk samples of {sel,seg} needed to accept a digit (range 1..255).
- TIMEOUT_CYC, 4096, clk cycles without any accepted digit before `stall` asserts (16-bit counter).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- led_o  in  8  segment bus, active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a.
- led_sel  in  4  digit select, active-low one-hot; 4'b1110=digit0 (rightmost) .. 4'b0111=digit3.
- clr  in  1  synchronous clear of err, stall, seen and the timeout counter.
- value  out  16  last complete frame, {digit3,digit2,digit1,digit0}.
- dp  out  4  decimal points of last complete frame, active-high, dp[i]=digit i.
- frame_valid  out  1  one-cycle pulse when value/dp update.
- seen  out  4  digits captured in the current partial frame.
- err  out  1  sticky; an accepted digit had an undecodable segment pattern.
- stall  out  1  sticky; timeout expired.

Behaviour:
- Reset (async): value=0, dp=0, frame_valid=0, seen=0, err=0, stall=0, FSM=IDLE, stable counter=0, timeout counter=0, input registers=all ones.
- Input stage: one register for {led_sel,led_o}. All decisions use the registered sample `s` and its previous sample `p`.
- sel_ok = s.sel has exactly one zero bit.
- FSM IDLE:
  - sel_ok -> SETTLE, count=1.
  - otherwise stay in IDLE.
- FSM SETTLE:
  - If !sel_ok or s!=p -> IDLE, count=0.
  - Else count++.
  - When count reaches STABLE_CYC, the digit is accepted that cycle -> HOLD.
  - STABLE_CYC=1 accepts on the first sel_ok sample.
- FSM HOLD:
  - Stays while s==p.
  - On any change: if sel_ok -> SETTLE with count=1, else -> IDLE.
  - Each slot is accepted at most once per stable period.
- Accept, decoding s.seg[6:0] to a nibble. Valid patterns, active-low:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
  - Valid pattern: write the nibble into the shadow slot given by sel, write the slot's dp as ~s.seg[7], and set seen[slot].
  - Invalid pattern (includes blank 7F): set err; shadow slot and seen unchanged.
- Re-accepting an already-seen slot before the frame completes overwrites the shadow nibble. seen is unchanged.
- Frame completion:
  - The cycle after seen becomes 4'b1111: value<=shadow, dp<=shadow dp, frame_valid=1 for exactly one cycle, seen<=0.
  - An accept in that same cycle lands in the new (cleared) frame.
- Timeout:
  - Counter clears on every accept and counts otherwise, saturating.
  - Reaching TIMEOUT_CYC sets stall; stall stays set until clr or rst.
- clr:
  - Clears err, stall, seen and the timeout counter next edge.
  - value, dp and FSM are untouched.
  - clr wins over a same-cycle err set or stall set.
- Latency: the last stable digit sample to frame_valid is 1 (input reg) + STABLE_CYC + 1 cycles.
- Reset mid-frame: the partial frame is discarded and value returns to 0.

Test Plan:
- STABLE_CYC=4: scan digits 0..3 showing 4,3,2,1, each held 10 cycles, dp off -> single frame_valid, value=16'h1234, dp=4'b0000, err=0.
- Glitch: while digit1 is stable, insert a 2-cycle segment change to 7'h00 -> not accepted; seen and value unaffected; frame still completes with the correct value.
- Invalid pattern 7'h7F on digit2 for 10 cycles -> err=1, seen[2]=0; then pulse clr -> err=0.
- led_sel=4'b0011 (two active) for 20 cycles -> no accept, FSM stays IDLE, seen unchanged.
- TIMEOUT_CYC=64 with led_sel=4'hF -> stall=1 at cycle 64+1, and it holds; clr clears it.
- Assert rst after 3 digits are accepted (seen=4'b0111) -> all outputs 0 immediately; a fresh 4-digit scan of ABCD -> value=16'hABCD.
